prbs9_ber_checker: RTL and testbench
====================================

# prbs9_ber_checker

Receive-side companion to the PRBS9 raised-cosine transmitter. Decimates one I or Q branch of the 4x-oversampled filter output to one sample per symbol, slices it to a hard bit, and self-synchronises a local PRBS9 (x^9+x^5+1) to the decided stream. Once locked, it accumulates bit and error counts for BER measurement. Two instances, one per branch, sit directly after the transmit filter outputs, or after the channel model when one is present.

## Interface
- NB_INPUT, 8: total bits of the signed input sample.
- NB_COUNT, 32: width of the bit and error accumulators.
- WIN_LEN, 64: symbols per lock-evaluation window; must be ≥ 16.
- LOCK_THR, 4: max errors per window that still count as locked.

Ports:
- clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  block enable (system switch).
- i_phase  in  2  oversampling phase (0..3) at which a symbol is taken.
- i_sample  in  NB_INPUT  signed filter output, one new sample per clock.
- i_clear  in  1  single-cycle pulse; clears the accumulators.
- o_hard_bit  out  1  last decided bit.
- o_locked  out  1  checker is in LOCKED.
- o_bit_count  out  NB_COUNT  symbols checked while locked.
- o_err_count  out  NB_COUNT  errors found while locked.

## Operation
- 2-bit phase counter: 0 after reset, then increments every clock and wraps 3→0. It runs regardless of i_enable.
- Strobe: asserted when the counter equals i_phase and i_enable=1. On a strobe, the sampled bit register takes i_sample MSB (negative sample → 1) and a valid flag is set for one cycle.
- Each valid symbol is processed by the FSM on the next edge. The 9-bit LFSR uses r[0] as the newest bit; the predicted bit is p = r[4]^r[8].
- LOAD (reset state): shift the received bit into r. After 9 symbols, go to TRAIN and clear the window counter and window error count.
- TRAIN: compare the received bit with p and add 1 to the window error count on mismatch. Shift p, not the received bit, into r. At the WIN_LEN-th symbol, go to LOCKED if window errors ≤ LOCK_THR, else go to LOAD.
- LOCKED: same compare and shift as TRAIN. Each symbol also increments o_bit_count, and each mismatch increments o_err_count. Windows are evaluated the same way; window errors > LOCK_THR at a window end sends the FSM to LOAD.
- Accumulators:
  - Hold value in LOAD, TRAIN, and when i_enable=0.
  - Both saturate at all-ones. Once o_bit_count saturates, both stop updating.
- i_clear: zeroes both accumulators and does not touch FSM, LFSR or window state. If it coincides with a counted symbol, clear wins and the result is 0.
- i_enable=0: FSM, LFSR, window logic and accumulators freeze; no strobes are generated.
- An i_phase change takes effect at the next counter match. A symbol may be skipped or duplicated; the window logic is responsible for recovery.
- Reset values: o_hard_bit=0, o_locked=0, both counts 0, FSM=LOAD, LFSR=0, window counter and window errors 0, phase counter 0.

## Timing
- Sampling edge E is the edge at which the counter equals i_phase. o_hard_bit updates at E.
- The FSM, LFSR, o_locked and accumulators reflect that symbol at E+1. Total latency from sample to count is 1 clock after capture.
- Symbol rate is one per 4 clocks, so there is no back-pressure and processing never overlaps.
- o_locked rises at E+1 of the WIN_LEN-th TRAIN symbol. It falls at E+1 of a failing LOCKED window end.
- With a clean stream, lock occurs after exactly 9 + WIN_LEN symbols.
- Reset mid-operation returns every register to its reset value on the same edge. i_reset has priority over i_clear and i_enable.

## Test plan
- Reset/idle: hold i_reset 4 clocks, then i_enable=0 for 40 clocks → all outputs 0, counter still cycling.
- Clean lock: ideal PRBS9 on the phase-2 slot (bit 0 → +64, 1 → −64, other phases 0), i_phase=2, defaults → o_locked rises after 73 symbols (292 clocks ±3). o_bit_count then increments by 1 every 4 clocks and o_err_count stays 0.
- Single error: while locked, flip one symbol → o_err_count +1 exactly, o_locked stays 1.
- Burst loss and relock: 10 flipped symbols within one window → o_locked falls at that window end, then relocks 73 symbols later. Accumulators hold during relock and resume afterwards.
- Wrong phase/inversion: feed the inverted PRBS → every TRAIN window has 64 errors, o_locked never rises, counts stay 0. Then set i_phase to a zero-sample slot → also no lock.
- Clear/enable/saturation: i_clear pulse while locked → counts read 0 next cycle, then continue. i_enable=0 for 100 clocks → counts and o_locked frozen. With NB_COUNT=4 → o_bit_count stops at 15.

Source files
------------

// File: rtl/prbs9_ber_checker.sv
// prbs9_ber_checker
// Receive-side PRBS9 (x^9+x^5+1) checker for one I or Q branch of the 4x
// oversampled raised-cosine filter output. It takes one sample per symbol at a
// selectable phase, slices it to a hard bit, self-synchronises a local PRBS9
// to the decided stream, and accumulates bit/error counts while locked.
//
// Ports:
//   clock        system clock
//   i_reset      synchronous, active-high reset
//   i_enable     block enable; 0 freezes everything except the phase counter
//   i_phase      oversampling phase (0..3) at which a symbol is taken
//   i_sample     signed filter output, one sample per clock
//   i_clear      single-cycle pulse, zeroes both accumulators
//   o_hard_bit   last decided bit (negative sample -> 1)
//   o_locked     checker is in LOCKED
//   o_bit_count  symbols checked while locked (saturating)
//   o_err_count  errors found while locked (saturating)
//
// States:
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_LOAD   | shift received bits straight into the LFSR (9 symbols)
//   ST_TRAIN  | free-run the LFSR, count window errors, decide on lock
//   ST_LOCKED | as TRAIN, plus accumulate bit/error counts; lose lock on a bad window

module prbs9_ber_checker #(
  parameter int NB_INPUT = 8,
  parameter int NB_COUNT = 32,
  parameter int WIN_LEN  = 64,
  parameter int LOCK_THR = 4
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [1:0]                 i_phase,
  input  logic signed [NB_INPUT-1:0] i_sample,
  input  logic                       i_clear,
  output logic                       o_hard_bit,
  output logic                       o_locked,
  output logic [NB_COUNT-1:0]        o_bit_count,
  output logic [NB_COUNT-1:0]        o_err_count
);

  localparam int NB_WIN  = $clog2(WIN_LEN);
  localparam int NB_WERR = $clog2(WIN_LEN + 1);

  localparam logic [NB_WIN-1:0]          WIN_LAST  = NB_WIN'(WIN_LEN - 1);
  localparam logic [NB_WERR-1:0]         WERR_THR  = NB_WERR'(LOCK_THR);
  localparam logic [3:0]                 LOAD_LAST = 4'd8;
  localparam logic signed [NB_INPUT-1:0] SAMPLE_ZERO = '0;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_TRAIN,
    ST_LOCKED
  } state_t;

  state_t               state;
  logic [1:0]           phase_cnt;
  logic                 sym_valid;
  logic [8:0]           lfsr;
  logic [3:0]           load_cnt;
  logic [NB_WIN-1:0]    win_cnt;
  logic [NB_WERR-1:0]   win_err;

  logic                 strobe_match;
  logic                 sym_go;
  logic                 pred_bit;
  logic                 sym_err;
  logic [NB_WERR-1:0]   win_err_nxt;
  logic                 win_end;
  logic                 win_pass;
  logic [8:0]           load_seed;
  logic                 bit_sat;
  logic                 err_sat;
  logic                 count_go;

  // Phase counter free-runs, independent of i_enable.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase_cnt <= 2'd0;
    end else begin
      phase_cnt <= phase_cnt + 2'd1;
    end
  end

  assign strobe_match = (phase_cnt == i_phase);

  // Symbol capture. While disabled the valid flag holds, so a captured symbol
  // is neither lost nor processed until the block is enabled again.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_hard_bit <= 1'b0;
      sym_valid  <= 1'b0;
    end else if (i_enable) begin
      sym_valid <= strobe_match;
      if (strobe_match) begin
        o_hard_bit <= (i_sample < SAMPLE_ZERO);
      end
    end
  end

  assign sym_go      = sym_valid & i_enable;
  assign pred_bit    = lfsr[4] ^ lfsr[8];
  assign sym_err     = o_hard_bit ^ pred_bit;
  assign win_err_nxt = win_err + NB_WERR'(sym_err);
  assign win_end     = (win_cnt == '0);
  assign win_pass    = (win_err_nxt <= WERR_THR);
  assign load_seed   = {lfsr[7:0], o_hard_bit};

  // A true PRBS9 stream never holds nine zeros in a row, so an all-zero seed
  // means the slot carries no signal (wrong phase, dead input). Seeding from it
  // would lock the LFSR in its stuck state and "match" silence, so keep loading.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state    <= ST_LOAD;
      lfsr     <= 9'd0;
      load_cnt <= LOAD_LAST;
      win_cnt  <= '0;
      win_err  <= '0;
      o_locked <= 1'b0;
    end else if (sym_go) begin
      case (state)
        ST_LOAD: begin
          lfsr <= load_seed;
          if (load_cnt == 4'd0) begin
            load_cnt <= LOAD_LAST;
            if (load_seed != 9'd0) begin
              state   <= ST_TRAIN;
              win_cnt <= WIN_LAST;
              win_err <= '0;
            end
          end else begin
            load_cnt <= load_cnt - 4'd1;
          end
        end
        ST_TRAIN, ST_LOCKED: begin
          lfsr <= {lfsr[7:0], pred_bit};
          if (win_end) begin
            win_cnt <= WIN_LAST;
            win_err <= '0;
            if (win_pass) begin
              state    <= ST_LOCKED;
              o_locked <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              load_cnt <= LOAD_LAST;
              o_locked <= 1'b0;
            end
          end else begin
            win_cnt <= win_cnt - NB_WIN'(1);
            win_err <= win_err_nxt;
          end
        end
        default: begin
          state    <= ST_LOAD;
          load_cnt <= LOAD_LAST;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bit_sat  = &o_bit_count;
  assign err_sat  = &o_err_count;
  assign count_go = sym_go && (state == ST_LOCKED) && !bit_sat;

  // Accumulators; clear wins over a coincident counted symbol.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_bit_count <= '0;
      o_err_count <= '0;
    end else if (i_clear) begin
      o_bit_count <= '0;
      o_err_count <= '0;
    end else if (count_go) begin
      o_bit_count <= o_bit_count + NB_COUNT'(1);
      if (sym_err && !err_sat) begin
        o_err_count <= o_err_count + NB_COUNT'(1);
      end
    end
  end

endmodule

// File: tb/tb_prbs9_ber_checker.sv
// Directed bench for prbs9_ber_checker: default instance plus a 4-bit
// accumulator instance sharing the same stimulus (saturation check).
// Cycle numbers below count edges since the last reset release; with the PRBS
// on phase slot 2, symbol k is captured at edge 4k-1 and processed at edge 4k.

module tb_prbs9_ber_checker;

  logic              clock = 1'b0;
  logic              i_reset;
  logic              i_enable;
  logic [1:0]        i_phase;
  logic signed [7:0] i_sample;
  logic              i_clear;

  logic              o_hard_bit;
  logic              o_locked;
  logic [31:0]       o_bit_count;
  logic [31:0]       o_err_count;

  logic              s_hard_bit;
  logic              s_locked;
  logic [3:0]        s_bit_count;
  logic [3:0]        s_err_count;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         sym_no = 0;
  logic [1:0] tb_ph = 2'd0;
  logic [8:0] gen = 9'h1FF;
  logic       invert = 1'b0;
  logic       flip_en = 1'b0;
  logic       saw_lock = 1'b0;

  always #5 clock = ~clock;

  prbs9_ber_checker dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_phase    (i_phase),
    .i_sample   (i_sample),
    .i_clear    (i_clear),
    .o_hard_bit (o_hard_bit),
    .o_locked   (o_locked),
    .o_bit_count(o_bit_count),
    .o_err_count(o_err_count)
  );

  prbs9_ber_checker #(.NB_COUNT(4)) dut_s (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_phase    (i_phase),
    .i_sample   (i_sample),
    .i_clear    (i_clear),
    .o_hard_bit (s_hard_bit),
    .o_locked   (s_locked),
    .o_bit_count(s_bit_count),
    .o_err_count(s_err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive the sample for the coming edge, then advance past it.
  task automatic step();
    logic b;
    if (tb_ph == 2'd2 && i_enable) begin
      b = gen[4] ^ gen[8];
      gen = {gen[7:0], b};
      sym_no++;
      if (invert) b = ~b;
      if (flip_en && (sym_no == 100 || (sym_no >= 150 && sym_no <= 159))) b = ~b;
      i_sample = b ? -8'sd64 : 8'sd64;
    end else begin
      i_sample = 8'sd0;
    end
    @(posedge clock);
    #1;
    tb_ph = tb_ph + 2'd1;
    cyc++;
    saw_lock = saw_lock | o_locked;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_sample = 8'sd0;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    i_reset = 1'b0;
    tb_ph   = 2'd0;
    cyc     = 0;
    sym_no  = 0;
    gen     = 9'h1FF;
  endtask

  initial begin
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_phase  = 2'd2;
    i_clear  = 1'b0;
    i_sample = 8'sd0;

    // Reset then idle with the block disabled.
    do_reset();
    repeat (40) step();
    check("idle_locked",   {31'd0, o_locked},   32'd0);
    check("idle_hard_bit", {31'd0, o_hard_bit}, 32'd0);
    check("idle_bit_cnt",  o_bit_count,         32'd0);
    check("idle_err_cnt",  o_err_count,         32'd0);

    // Clean PRBS on slot 2; seed 1FF gives bits 0,0,0,0,0,1,1,1,1,...
    i_enable = 1'b1;
    flip_en  = 1'b1;
    do_reset();
    run_to(22);
    check("hard_bit_sym5", {31'd0, o_hard_bit}, 32'd0);
    run_to(23);
    check("hard_bit_sym6", {31'd0, o_hard_bit}, 32'd1);

    // Lock after 9 + 64 = 73 symbols -> edge 292.
    run_to(291);
    check("pre_lock",       {31'd0, o_locked}, 32'd0);
    run_to(292);
    check("lock_edge",      {31'd0, o_locked}, 32'd1);
    check("lock_bit_cnt",   o_bit_count,       32'd0);

    // 20 counted symbols (74..93); 4-bit copy stops at 15.
    run_to(372);
    check("run_bit_cnt",    o_bit_count,       32'd20);
    check("run_err_cnt",    o_err_count,       32'd0);
    check("sat_bit_cnt",    {28'd0, s_bit_count}, 32'd15);

    // Symbol 100 flipped.
    run_to(420);
    check("single_bit_cnt", o_bit_count,       32'd32);
    check("single_err_cnt", o_err_count,       32'd1);
    check("single_locked",  {31'd0, o_locked}, 32'd1);
    check("sat_err_frozen", {28'd0, s_err_count}, 32'd0);

    // Symbols 150..159 flipped; window 138..201 fails at edge 804.
    run_to(803);
    check("burst_pre_end",  {31'd0, o_locked}, 32'd1);
    check("burst_bit_pre",  o_bit_count,       32'd127);
    run_to(804);
    check("burst_unlock",   {31'd0, o_locked}, 32'd0);
    check("burst_bit_cnt",  o_bit_count,       32'd128);
    check("burst_err_cnt",  o_err_count,       32'd11);

    // Relock at symbol 201 + 73 = 274 -> edge 1096, counts held meanwhile.
    run_to(1095);
    check("relock_pre",     {31'd0, o_locked}, 32'd0);
    check("relock_hold_b",  o_bit_count,       32'd128);
    run_to(1096);
    check("relock_edge",    {31'd0, o_locked}, 32'd1);
    check("relock_hold_e",  o_err_count,       32'd11);
    run_to(1176);
    check("resume_bit_cnt", o_bit_count,       32'd148);

    // Clear coinciding with counted symbol 295 at edge 1180.
    run_to(1179);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check("clear_bit_cnt",  o_bit_count,       32'd0);
    check("clear_err_cnt",  o_err_count,       32'd0);
    check("clear_locked",   {31'd0, o_locked}, 32'd1);
    check("clear_sat_bit",  {28'd0, s_bit_count}, 32'd0);
    run_to(1200);
    check("post_clear_cnt", o_bit_count,       32'd5);
    check("post_clear_sat", {28'd0, s_bit_count}, 32'd5);

    // Disabled for 100 clocks: everything frozen.
    i_enable = 1'b0;
    run_to(1300);
    check("dis_bit_cnt",    o_bit_count,       32'd5);
    check("dis_locked",     {31'd0, o_locked}, 32'd1);
    i_enable = 1'b1;
    run_to(1400);
    check("reen_bit_cnt",   o_bit_count,       32'd30);
    check("reen_err_cnt",   o_err_count,       32'd0);
    check("reen_locked",    {31'd0, o_locked}, 32'd1);

    // Reset mid-operation clears on the same edge.
    i_reset  = 1'b1;
    i_sample = 8'sd0;
    @(posedge clock);
    #1;
    check("midrst_locked",  {31'd0, o_locked}, 32'd0);
    check("midrst_bit_cnt", o_bit_count,       32'd0);
    check("midrst_hard",    {31'd0, o_hard_bit}, 32'd0);

    // Inverted PRBS: every window fails, never locks.
    flip_en  = 1'b0;
    invert   = 1'b1;
    do_reset();
    saw_lock = 1'b0;
    run_to(1100);
    check("inv_never_lock", {31'd0, saw_lock}, 32'd0);
    check("inv_bit_cnt",    o_bit_count,       32'd0);
    check("inv_err_cnt",    o_err_count,       32'd0);

    // Sampling a silent slot: no lock either.
    invert   = 1'b0;
    i_phase  = 2'd0;
    saw_lock = 1'b0;
    run_to(1600);
    check("zero_never_lock", {31'd0, saw_lock}, 32'd0);
    check("zero_bit_cnt",    o_bit_count,       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
